// File: rtl/tone_synth_pkg.sv
// Shared types and limits for the multi-voice DDS tone synthesiser.
// Imported by the datapath and the sine ROM.
package tone_synth_pkg;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_MAC,
        ST_OUT
    } state_e;

    localparam int MAX_CHANNELS = 8;
    localparam int WAVE_LIM     = 127;

endpackage

// File: rtl/tone_synth_dds_quarter_sin_rom.sv
// Quarter-wave sine table, round(127*sin), registered output.
// Entries are built at elaboration from a Taylor series.
module quarter_sin_rom
    import tone_synth_pkg::*;
#(
    parameter  int TABLE_BITS = 8,
    localparam int Q_W        = TABLE_BITS - 2
) (
    input  logic           clk,
    input  logic [Q_W-1:0] addr,
    output logic [6:0]     data
);

    function automatic int qsin(int i);
        real x;
        real term;
        real s;
        x    = 6.283185307179586 * real'(i) / real'(1 << TABLE_BITS);
        term = x;
        s    = x;
        for (int k = 1; k < 10; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        return $rtoi(real'(WAVE_LIM) * s + 0.5);
    endfunction

    logic [6:0] tbl [2**Q_W];

    for (genvar g = 0; g < 2**Q_W; g++) begin : g_tbl
        localparam int V = qsin(g);
        assign tbl[g] = 7'(V);
    end

    always_ff @(posedge clk) begin
        data <= tbl[addr];
    end

endmodule

// File: rtl/tone_synth_dds.sv
// Multi-voice DDS tone synthesiser: per frame, one ADDR/MAC pair
// per channel, then a saturated mixed sample.
module tone_synth_dds
    import tone_synth_pkg::*;
#(
    parameter  int CHANNELS   = 4,
    parameter  int PHASE_W    = 24,
    parameter  int TABLE_BITS = 8,
    parameter  int OUT_W      = 16,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_tick,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [PHASE_W-1:0]      wr_inc,
    input  logic [1:0]              wr_mode,
    input  logic [7:0]              wr_amp,
    output logic signed [OUT_W-1:0] sample,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int ACC_W = OUT_W + $clog2(CHANNELS) + 1;
    localparam int Q_W   = TABLE_BITS - 2;
    localparam logic signed [7:0] WL = 8'(WAVE_LIM);

    state_e state, state_nx;
    logic [CH_W-1:0] ch;
    logic            last_ch;

    logic [PHASE_W-1:0] phase  [CHANNELS];
    logic [PHASE_W-1:0] inc_sh [CHANNELS];
    logic [PHASE_W-1:0] inc_ac [CHANNELS];
    logic [1:0]         mode_sh [CHANNELS];
    logic [1:0]         mode_ac [CHANNELS];
    logic [7:0]         amp_sh [CHANNELS];
    logic [7:0]         amp_ac [CHANNELS];

    logic [PHASE_W-1:0]    phase_nx;
    logic [TABLE_BITS-1:0] tbl_addr;
    logic [Q_W-1:0]        rom_addr;
    logic [6:0]            rom_data;
    logic                  sin_peak, sin_neg;

    logic [7:0]              p_top;
    logic [6:0]              tri_m;
    logic [12:0]             tri_prod;
    logic signed [7:0]       mag, saw, wave;
    logic signed [8:0]       amp_s;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] acc, acc_sum;
    logic [ACC_W-OUT_W:0]    upper;
    logic signed [OUT_W-1:0] sat_val;

    assign last_ch      = (ch == CH_W'(CHANNELS - 1));
    assign busy         = (state != ST_IDLE);
    assign sample_valid = (state == ST_OUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (sample_tick) state_nx = ST_ADDR;
            ST_ADDR: state_nx = ST_MAC;
            ST_MAC:  state_nx = last_ch ? ST_OUT : ST_ADDR;
            ST_OUT:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Odd quadrants read the table mirrored; index 0 there is the
    // unstored +127 peak.
    always_comb begin
        phase_nx = phase[ch] + inc_ac[ch];
        tbl_addr = phase_nx[PHASE_W-1 -: TABLE_BITS];
        rom_addr = tbl_addr[TABLE_BITS-2] ? (~tbl_addr[Q_W-1:0] + 1'b1)
                                          : tbl_addr[Q_W-1:0];
    end

    quarter_sin_rom #(.TABLE_BITS(TABLE_BITS)) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    always_comb begin
        p_top    = phase[ch][PHASE_W-1 -: 8];
        tri_m    = p_top[6] ? (7'd64 - {1'b0, p_top[5:0]})
                            : {1'b0, p_top[5:0]};
        tri_prod = 13'(tri_m) * 13'd127 + 13'd32;
        saw      = signed'(p_top ^ 8'h80);
        mag      = '0;
        wave     = '0;
        unique case (wave_e'(mode_ac[ch]))
            WAVE_SINE: begin
                mag  = sin_peak ? WL : signed'({1'b0, rom_data});
                wave = sin_neg ? -mag : mag;
            end
            WAVE_SQUARE: wave = p_top[7] ? -WL : WL;
            WAVE_TRI: begin
                mag  = signed'({1'b0, tri_prod[12:6]});
                wave = p_top[7] ? -mag : mag;
            end
            WAVE_SAW: wave = (saw == 8'sh80) ? -WL : saw;
            default:  wave = '0;
        endcase
        amp_s   = signed'({1'b0, amp_ac[ch]});
        prod    = 16'(wave) * 16'(amp_s);
        acc_sum = acc + ACC_W'(prod);
        upper   = acc_sum[ACC_W-1:OUT_W-1];
        if (&upper || !(|upper))
            sat_val = acc_sum[OUT_W-1:0];
        else if (acc_sum[ACC_W-1])
            sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        else
            sat_val = {1'b0, {(OUT_W-1){1'b1}}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch       <= '0;
            acc      <= '0;
            sample   <= '0;
            sin_peak <= 1'b0;
            sin_neg  <= 1'b0;
            overrun  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                phase[i]   <= '0;
                inc_sh[i]  <= '0;
                inc_ac[i]  <= '0;
                mode_sh[i] <= '0;
                mode_ac[i] <= '0;
                amp_sh[i]  <= '0;
                amp_ac[i]  <= '0;
            end
        end else begin
            overrun <= sample_tick && (state != ST_IDLE);
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && wr_ch == CH_W'(i)) begin
                    inc_sh[i]  <= wr_inc;
                    mode_sh[i] <= wr_mode;
                    amp_sh[i]  <= wr_amp;
                end
            end
            unique case (state)
                ST_IDLE: begin
                    if (sample_tick) begin
                        ch  <= '0;
                        acc <= '0;
                        for (int i = 0; i < CHANNELS; i++) begin
                            inc_ac[i]  <= inc_sh[i];
                            mode_ac[i] <= mode_sh[i];
                            amp_ac[i]  <= amp_sh[i];
                        end
                    end
                end
                ST_ADDR: begin
                    phase[ch] <= phase_nx;
                    sin_peak  <= tbl_addr[TABLE_BITS-2] &&
                                 (tbl_addr[Q_W-1:0] == '0);
                    sin_neg   <= tbl_addr[TABLE_BITS-1];
                end
                ST_MAC: begin
                    acc <= acc_sum;
                    if (last_ch) sample <= sat_val;
                    else         ch <= ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_synth_dds.sv
// Scoreboard bench for tone_synth_dds with a real-valued
// waveform model and a decoupled output monitor.
module tb_tone_synth_dds;

    localparam int CH = 4;

    typedef struct {
        int smp;
        int at;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_tick;
    logic               wr_en;
    logic [1:0]         wr_ch;
    logic [23:0]        wr_inc;
    logic [1:0]         wr_mode;
    logic [7:0]         wr_amp;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               busy;
    logic               overrun;

    tone_synth_dds dut (
        .clk          (clk),
        .reset        (rst),
        .sample_tick  (sample_tick),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_inc       (wr_inc),
        .wr_mode      (wr_mode),
        .wr_amp       (wr_amp),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] sh_inc  [CH];
    logic [23:0] m_phase [CH];
    int          sh_mode [CH];
    int          sh_amp  [CH];
    exp_t        sbq [$];
    int tests, fails;
    int free_cyc, ov_seen, ov_exp, busy_cnt, last_sample;

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int round_sym(real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    // Ideal waveforms as functions of the phase fraction.
    function automatic int ref_wave(int mode, int top);
        real ph;
        real t;
        ph = real'(top) / 256.0;
        case (mode)
            0: return round_sym(127.0 * $sin(6.283185307179586 * ph));
            1: return (ph < 0.5) ? 127 : -127;
            2: begin
                if (ph < 0.25)      t = 4.0 * ph;
                else if (ph < 0.75) t = 2.0 - 4.0 * ph;
                else                t = 4.0 * ph - 4.0;
                return round_sym(127.0 * t);
            end
            default: return (top - 128 < -127) ? -127 : top - 128;
        endcase
    endfunction

    function automatic int ref_frame();
        longint sum;
        sum = 0;
        for (int i = 0; i < CH; i++) begin
            m_phase[i] = m_phase[i] + sh_inc[i];
            sum += ref_wave(sh_mode[i], int'(m_phase[i][23:16])) * sh_amp[i];
        end
        if (sum > 32767)  return 32767;
        if (sum < -32768) return -32768;
        return int'(sum);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            sh_inc[i]  = '0;
            m_phase[i] = '0;
            sh_mode[i] = 0;
            sh_amp[i]  = 0;
        end
        sbq.delete();
        free_cyc = 0;
    endfunction

    task automatic do_write(int ch, int inc, int mode, int amp);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_inc  = 24'(inc);
        wr_mode = 2'(mode);
        wr_amp  = 8'(amp);
        sh_inc[ch]  = 24'(inc);
        sh_mode[ch] = mode;
        sh_amp[ch]  = amp;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rand_write();
        do_write($urandom_range(0, CH - 1), $urandom_range(0, 24'hFFFFFF),
                 $urandom_range(0, 3), $urandom_range(0, 255));
    endtask

    task automatic do_tick();
        @(negedge clk);
        sample_tick = 1'b1;
        if (cyc >= free_cyc) begin
            sbq.push_back('{smp: ref_frame(), at: cyc + 9});
            free_cyc = cyc + 10;
        end else begin
            ov_exp++;
        end
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", sbq.size(), 0);
            sbq.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (overrun) ov_seen++;
        if (sample_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", int'(sample_valid), 0);
            end else begin
                e = sbq.pop_front();
                chk("sample", sample, e.smp);
                chk("latency", cyc, e.at);
            end
            last_sample = sample;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e35[4];
        e35 = '{32385, 0, -32385, 0};
        rst = 1'b1;
        sample_tick = 1'b0;
        wr_en = 1'b0;
        wr_ch = '0;
        wr_inc = '0;
        wr_mode = '0;
        wr_amp = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_sample", sample, 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b0;

        busy_cnt = 0;
        last_sample = -1;
        do_tick();
        wait_idle();
        chk("t34_busy_cycles", busy_cnt, 9);
        chk("t34_sample", last_sample, 0);

        for (int i = 0; i < CH; i++) do_write(i, 0, 1, 255);
        do_tick();
        wait_idle();
        chk("t36_saturate", last_sample, 32767);

        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_write(0, 1 << 22, 0, 255);
        for (int k = 0; k < 4; k++) begin
            do_tick();
            wait_idle();
            chk("t35_sine", last_sample, e35[k]);
        end

        do_write(0, 1 << 22, 1, 255);
        do_tick();
        do_write(0, 1 << 22, 1, 100);
        wait_idle();
        chk("t38_same_frame", last_sample, 32385);
        do_tick();
        wait_idle();
        chk("t38_next_frame", last_sample, -12700);

        do_tick();
        repeat (2) @(negedge clk);
        do_tick();
        chk("t37_overrun_hi", int'(overrun), 1);
        @(negedge clk);
        chk("t37_overrun_lo", int'(overrun), 0);
        wait_idle();
        repeat (12) @(negedge clk);
        chk("t37_no_second", int'(busy), 0);

        repeat (25) begin
            repeat ($urandom_range(0, 3)) rand_write();
            do_tick();
            if ($urandom_range(0, 1) == 1) rand_write();
            wait_idle();
        end

        do_write(2, 24'h123456, 3, 200);
        do_tick();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        chk("t39_sample", sample, 0);
        chk("t39_valid", int'(sample_valid), 0);
        chk("t39_busy", int'(busy), 0);
        chk("t39_overrun", int'(overrun), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        do_write(0, 1 << 22, 0, 200);
        do_write(1, 1 << 21, 2, 100);
        do_tick();
        wait_idle();
        chk("t39_restart", last_sample, 31800);

        wait_idle();
        chk("overrun_count", ov_seen, ov_exp);
        chk("queue_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
